lsu_stage: RTL and testbench
============================

# lsu_stage

Parametrised EXE→MEM pipeline register plus load/store unit for the in-order core, replacing the single-cycle memory stage. Latches EXE results and memory-op controls, then runs a request/grant/response handshake to data memory. It formats load data (sign/zero extension, lane select) and store data (lane replication, byte enables), stalling the pipeline while an access is outstanding. It sits between the execute stage and writeback, with `busy_mem` feeding the hazard unit.

## Interface
- `DATA_W`, 32: data bus and register width; 32 or 64.
- `ADDR_W`, 32: byte address width.
- `RA_W`, 5: register address width.
- `clk`  in  1  clock.
- `rst_b`  in  1  asynchronous active-low reset.
- `hold_ctl`  in  1  hazard-unit hold; MEM register keeps contents.
- `clear_ctl`  in  1  flush; MEM entry becomes a bubble.
- `reg_wen_exe`, `reg_waddr_exe`, `reg_wdata_exe`  in  1/RA_W/DATA_W  EXE writeback info.
- `mem_rd_exe`, `mem_wr_exe`  in  1 each  load / store (never both).
- `mem_size_exe`  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- `mem_uns_exe`  in  1  zero-extend load.
- `mem_addr_exe`  in  ADDR_W  byte address.
- `st_data_exe`  in  DATA_W  store source (rs2).
- `bus_req`, `bus_we`  out  1 each  request / write.
- `bus_addr`  out  ADDR_W  address, low log2(DATA_W/8) bits zeroed.
- `bus_wdata`  out  DATA_W  lane-replicated store data.
- `bus_be`  out  DATA_W/8  byte enables.
- `bus_gnt`, `bus_rvalid`  in  1 each  grant / read response.
- `bus_rdata`  in  DATA_W  read data.
- `busy_mem`  out  1  access in MEM not yet complete.
- `misalign_mem`  out  1  misaligned access in MEM (macro-dependent).
- `reg_wen_mem`, `reg_waddr_mem`, `reg_wdata_mem`  out  1/RA_W/DATA_W  to writeback; `reg_wdata_mem` is the formatted load result for loads.

## Operation
- MEM register loads from EXE when `~hold_ctl & ~busy_mem`. Priority: reset > busy/hold (keep) > clear (bubble) > load.
- `clear_ctl` while FSM is in REQ/WAIT: set internal `kill` and force `reg_wen_mem`=0. The FSM still completes, then the register takes a bubble.
- FSM states:
  - IDLE: a valid mem op drives `bus_req`. On `bus_gnt`, a store goes to DONE and a load goes to WAIT; without a grant, go to REQ.
  - REQ: hold `bus_req` and all bus fields stable until `bus_gnt`, then move as from IDLE.
  - WAIT: on `bus_rvalid`, capture the formatted data into the hold register and go to DONE.
  - DONE: when the register advances, go to IDLE, or stay busy on a new op.
- `complete_now` = (store & gnt) | (load & rvalid). `busy_mem` = mem op valid & state≠DONE & ~complete_now.
- Load result: formatted `bus_rdata` when `complete_now`, else the hold register. It stays stable across `hold_ctl`.
- Format (lane = addr low bits): extract a size-wide field, then sign-extend unless `mem_uns`. For stores, replicate `st_data[size-1:0]` across the bus; `bus_be` = size mask shifted by lane.

## Timing
- Store with immediate grant: zero stall cycles. Load: at least one stall cycle (rvalid no earlier than the cycle after grant).
- Reset values: all outputs 0, state IDLE, hold register 0, `kill` 0.
- Reset mid-access: drop the request immediately. Any later `bus_rvalid` is ignored.
- `hold_ctl` and `clear_ctl` together: hold wins and the entry is kept.
- `bus_rvalid` outside WAIT: ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: an access with addr not a multiple of its size sets `misalign_mem`=1 (stays 1 while the entry is in MEM). There is no bus request, `reg_wen_mem`=0, and the FSM goes straight to DONE.
- Undefined: `misalign_mem` is tied 0, and the address low bits below the size alignment are forced to zero before access.

## Structure
- `lsu_pkg`: size encodings, FSM state enum, `BE_W = DATA_W/8`, lane-width function.
- Sub-module `lsu_align`: purely combinational load extract/extend and store replicate/byte-enable generation. The top level holds the register, FSM and hold register.

## Test plan
- DATA_W=32, `lb` addr 0x1003, rdata 0x80FF_0000 → `reg_wdata_mem`=0xFFFF_FF80; `busy_mem` high for exactly 1 cycle with gnt in cycle 0 and rvalid in cycle 1.
- `sh` addr 0x2002, st_data 0x1234_ABCD, gnt immediate → `bus_be`=4'b1100, `bus_wdata`=0xABCD_ABCD, `busy_mem`=0.
- `bus_gnt` withheld 3 cycles → `bus_req`/`bus_addr` stable for 4 cycles, EXE inputs not sampled, `busy_mem`=1.
- `clear_ctl` during WAIT, then rvalid → access completes, `reg_wen_mem`=0, next cycle bubble.
- `hold_ctl` pulsed 2 cycles after load completion, data 0xDEAD_BEEF → `reg_wdata_mem` holds 0xDEAD_BEEF throughout.
- With `LSU_MISALIGN_TRAP_EN`, `lw` addr 0x1002 → `misalign_mem`=1, `bus_req`=0, `reg_wen_mem`=0. Without it, `bus_addr`=0x1000 and the load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size encodings, FSM states and lane helpers for the load/store stage
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // byte enables per data word
   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

   // number of bytes touched by an access of the given size code
   function automatic int lane_bytes(input logic [1:0] size);
      return 1 << size;
   endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// rtl/lsu_bus_if.sv - request/grant/response data-memory bus between LSU and memory
interface lsu_bus_if
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int BE_W = be_width(DATA_W);

   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [BE_W-1:0]   bus_be;
   logic              bus_gnt;
   logic              bus_rvalid;
   logic [DATA_W-1:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_gnt, bus_rvalid, bus_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load extract/extend and store replicate/byte-enable
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANE_W = $clog2(DATA_W / 8)
) (
   input  logic [1:0]          size,
   input  logic                uns,
   input  logic [LANE_W-1:0]   lane,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [DATA_W-1:0]   st_data,
   output logic [DATA_W-1:0]   ld_data,
   output logic [DATA_W-1:0]   st_wdata,
   output logic [DATA_W/8-1:0] st_be
);
   localparam int BE_W = be_width(DATA_W);

   logic [DATA_W-1:0] shifted;
   logic              ext;
   int                nbytes;
   int                lane_i;

   // load path: move the addressed lane to bit 0, then sign/zero extend above the field
   always_comb begin
      nbytes  = lane_bytes(size);
      if (nbytes > BE_W) nbytes = BE_W;
      shifted = rdata >> {lane, 3'b000};
      case (size)
         SZ_BYTE: ext = shifted[7];
         SZ_HALF: ext = shifted[15];
         SZ_WORD: ext = shifted[31];
         default: ext = shifted[DATA_W-1];
      endcase
      ext = ext & ~uns;
      for (int i = 0; i < DATA_W; i++) begin
         ld_data[i] = (i < nbytes * 8) ? shifted[i] : ext;
      end
   end

   // store path: replicate the low field across the word, enable only the addressed bytes
   always_comb begin
      lane_i = int'(lane);
      case (size)
         SZ_BYTE: st_wdata = {BE_W{st_data[7:0]}};
         SZ_HALF: st_wdata = {(BE_W / 2){st_data[15:0]}};
         SZ_WORD: st_wdata = {(DATA_W / 32){st_data[31:0]}};
         default: st_wdata = st_data;
      endcase
      for (int b = 0; b < BE_W; b++) begin
         st_be[b] = (b >= lane_i) && (b < lane_i + nbytes);
      end
   end

endmodule

// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - EXE->MEM register, bus FSM and load hold register; LSU_MISALIGN_TRAP_EN enables misalign trapping
module lsu_stage
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int RA_W   = 5
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              hold_ctl,
   input  logic              clear_ctl,
   input  logic              reg_wen_exe,
   input  logic [RA_W-1:0]   reg_waddr_exe,
   input  logic [DATA_W-1:0] reg_wdata_exe,
   input  logic              mem_rd_exe,
   input  logic              mem_wr_exe,
   input  logic [1:0]        mem_size_exe,
   input  logic              mem_uns_exe,
   input  logic [ADDR_W-1:0] mem_addr_exe,
   input  logic [DATA_W-1:0] st_data_exe,
   lsu_bus_if.master         bus,
   output logic              busy_mem,
   output logic              misalign_mem,
   output logic              reg_wen_mem,
   output logic [RA_W-1:0]   reg_waddr_mem,
   output logic [DATA_W-1:0] reg_wdata_mem
);
   localparam int BE_W   = be_width(DATA_W);
   localparam int LANE_W = $clog2(BE_W);

   lsu_state_e        state_q, state_d;
   logic              reg_wen_q, reg_wen_d;
   logic [RA_W-1:0]   reg_waddr_q, reg_waddr_d;
   logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [1:0]        mem_size_q, mem_size_d;
   logic              mem_uns_q, mem_uns_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] st_data_q, st_data_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              kill_q, kill_d;

   logic              mem_op, mis;
   logic [LANE_W-1:0] lane_raw, lane;
   int                nbytes;
   logic              bus_req_c, gnt_eff, rv_eff, complete_now, busy_c, advance;
   logic [DATA_W-1:0] ld_fmt, st_wdata;
   logic [BE_W-1:0]   st_be;

   // decode the MEM entry: op present, byte lane and (optionally) misalignment
   always_comb begin
      mem_op   = mem_rd_q | mem_wr_q;
      nbytes   = lane_bytes(mem_size_q);
      lane_raw = mem_addr_q[LANE_W-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
      mis  = mem_op & ((int'(lane_raw) & (nbytes - 1)) != 0);
      lane = lane_raw;
`else
      mis  = 1'b0;
      lane = LANE_W'(int'(lane_raw) & ~(nbytes - 1));
`endif
   end

   lsu_align #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_align (
      .size     (mem_size_q),
      .uns      (mem_uns_q),
      .lane     (lane),
      .rdata    (bus.bus_rdata),
      .st_data  (st_data_q),
      .ld_data  (ld_fmt),
      .st_wdata (st_wdata),
      .st_be    (st_be)
   );

   // FSM outputs: request, effective handshakes, completion and stall
   always_comb begin
      bus_req_c    = mem_op & ~mis & ((state_q == ST_IDLE) | (state_q == ST_REQ));
      gnt_eff      = bus_req_c & bus.bus_gnt;
      rv_eff       = (state_q == ST_WAIT) & mem_rd_q & bus.bus_rvalid;
      complete_now = (mem_wr_q & gnt_eff) | (mem_rd_q & rv_eff);
      busy_c       = mem_op & (state_q != ST_DONE) & ~complete_now;
      advance      = ~hold_ctl & ~busy_c;
   end

   // FSM next state; a completed access skips DONE when the register advances the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               if (mis)          state_d = ST_DONE;
               else if (gnt_eff) state_d = mem_wr_q ? (advance ? ST_IDLE : ST_DONE) : ST_WAIT;
               else              state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (gnt_eff) state_d = mem_wr_q ? (advance ? ST_IDLE : ST_DONE) : ST_WAIT;
         end
         ST_WAIT: begin
            if (rv_eff) state_d = advance ? ST_IDLE : ST_DONE;
         end
         default: begin
            if (advance) state_d = ST_IDLE;
         end
      endcase
   end

   // MEM register, load hold register and kill flag next values
   always_comb begin
      reg_wen_d   = reg_wen_q;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      mem_size_d  = mem_size_q;
      mem_uns_d   = mem_uns_q;
      mem_addr_d  = mem_addr_q;
      st_data_d   = st_data_q;
      hold_d      = rv_eff ? ld_fmt : hold_q;
      kill_d      = kill_q;
      if (advance) begin
         kill_d = 1'b0;
         if (clear_ctl | kill_q) begin
            reg_wen_d   = 1'b0;
            reg_waddr_d = '0;
            reg_wdata_d = '0;
            mem_rd_d    = 1'b0;
            mem_wr_d    = 1'b0;
            mem_size_d  = '0;
            mem_uns_d   = 1'b0;
            mem_addr_d  = '0;
            st_data_d   = '0;
         end else begin
            reg_wen_d   = reg_wen_exe;
            reg_waddr_d = reg_waddr_exe;
            reg_wdata_d = reg_wdata_exe;
            mem_rd_d    = mem_rd_exe;
            mem_wr_d    = mem_wr_exe;
            mem_size_d  = mem_size_exe;
            mem_uns_d   = mem_uns_exe;
            mem_addr_d  = mem_addr_exe;
            st_data_d   = st_data_exe;
         end
      end else if (clear_ctl & ~hold_ctl & busy_c) begin
         // flush arrived mid-access: let the bus transaction finish, drop its writeback
         kill_d = 1'b1;
      end
   end

   // state and storage flops
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= ST_IDLE;
         reg_wen_q   <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_size_q  <= '0;
         mem_uns_q   <= 1'b0;
         mem_addr_q  <= '0;
         st_data_q   <= '0;
         hold_q      <= '0;
         kill_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         reg_wen_q   <= reg_wen_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_size_q  <= mem_size_d;
         mem_uns_q   <= mem_uns_d;
         mem_addr_q  <= mem_addr_d;
         st_data_q   <= st_data_d;
         hold_q      <= hold_d;
         kill_q      <= kill_d;
      end
   end

   assign bus.bus_req    = bus_req_c;
   assign bus.bus_we     = bus_req_c & mem_wr_q;
   assign bus.bus_addr   = {mem_addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
   assign bus.bus_wdata  = st_wdata;
   assign bus.bus_be     = bus_req_c ? st_be : '0;

   assign busy_mem      = busy_c;
   assign misalign_mem  = mis;
   assign reg_wen_mem   = reg_wen_q & ~kill_q & ~mis;
   assign reg_waddr_mem = reg_waddr_q;
   assign reg_wdata_mem = mem_rd_q ? (complete_now ? ld_fmt : hold_q) : reg_wdata_q;

endmodule

// File: tb/tb_lsu_stage.sv
// tb/tb_lsu_stage.sv - directed self-checking bench for lsu_stage (DATA_W=32)
module tb_lsu_stage;

   logic        clk;
   logic        rst_b;
   logic        hold_ctl, clear_ctl;
   logic        reg_wen_exe;
   logic [4:0]  reg_waddr_exe;
   logic [31:0] reg_wdata_exe;
   logic        mem_rd_exe, mem_wr_exe;
   logic [1:0]  mem_size_exe;
   logic        mem_uns_exe;
   logic [31:0] mem_addr_exe;
   logic [31:0] st_data_exe;
   logic        busy_mem, misalign_mem, reg_wen_mem;
   logic [4:0]  reg_waddr_mem;
   logic [31:0] reg_wdata_mem;

   int checks   = 0;
   int failures = 0;

   lsu_bus_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   lsu_stage #(.DATA_W(32), .ADDR_W(32), .RA_W(5)) dut (
      .clk           (clk),
      .rst_b         (rst_b),
      .hold_ctl      (hold_ctl),
      .clear_ctl     (clear_ctl),
      .reg_wen_exe   (reg_wen_exe),
      .reg_waddr_exe (reg_waddr_exe),
      .reg_wdata_exe (reg_wdata_exe),
      .mem_rd_exe    (mem_rd_exe),
      .mem_wr_exe    (mem_wr_exe),
      .mem_size_exe  (mem_size_exe),
      .mem_uns_exe   (mem_uns_exe),
      .mem_addr_exe  (mem_addr_exe),
      .st_data_exe   (st_data_exe),
      .bus           (bus),
      .busy_mem      (busy_mem),
      .misalign_mem  (misalign_mem),
      .reg_wen_mem   (reg_wen_mem),
      .reg_waddr_mem (reg_waddr_mem),
      .reg_wdata_mem (reg_wdata_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exe_op(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] st, input logic wen,
                         input logic [4:0] waddr, input logic [31:0] wdata);
      mem_rd_exe    = rd;
      mem_wr_exe    = wr;
      mem_size_exe  = size;
      mem_uns_exe   = uns;
      mem_addr_exe  = addr;
      st_data_exe   = st;
      reg_wen_exe   = wen;
      reg_waddr_exe = waddr;
      reg_wdata_exe = wdata;
   endtask

   task automatic exe_idle();
      exe_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      rst_b          = 1'b0;
      hold_ctl       = 1'b0;
      clear_ctl      = 1'b0;
      exe_idle();
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b0;
      bus.bus_rdata  = 32'h0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req", bus.bus_req, 0);
      check("rst_busy", busy_mem, 0);
      check("rst_wen", reg_wen_mem, 0);
      check("rst_wdata", reg_wdata_mem, 0);
      check("rst_addr", bus.bus_addr, 0);
      check("rst_be", bus.bus_be, 0);
      check("rst_mis", misalign_mem, 0);
      tick();
      rst_b = 1'b1;

      // lb 0x1003: grant in cycle 0, rvalid in cycle 1
      exe_op(1, 0, 2'd0, 0, 32'h1003, 32'h0, 1, 5'd5, 32'h1111);
      tick();
      exe_idle();
      bus.bus_gnt = 1'b1;
      @(negedge clk);
      check("lb_req", bus.bus_req, 1);
      check("lb_we", bus.bus_we, 0);
      check("lb_addr", bus.bus_addr, 32'h1000);
      check("lb_be", bus.bus_be, 4'b1000);
      check("lb_busy_c0", busy_mem, 1);
      tick();
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'h80FF_0000;
      @(negedge clk);
      check("lb_busy_c1", busy_mem, 0);
      check("lb_wen", reg_wen_mem, 1);
      check("lb_waddr", reg_waddr_mem, 5);
      check("lb_data", reg_wdata_mem, 32'hFFFF_FF80);
      check("lb_req_c1", bus.bus_req, 0);
      tick();
      bus.bus_rvalid = 1'b0;
      @(negedge clk);
      check("lb_after_wen", reg_wen_mem, 0);
      check("lb_after_busy", busy_mem, 0);

      // sh 0x2002 with immediate grant
      exe_op(0, 1, 2'd1, 0, 32'h2002, 32'h1234_ABCD, 0, 5'd0, 32'h0);
      tick();
      exe_idle();
      bus.bus_gnt = 1'b1;
      @(negedge clk);
      check("sh_req", bus.bus_req, 1);
      check("sh_we", bus.bus_we, 1);
      check("sh_addr", bus.bus_addr, 32'h2000);
      check("sh_be", bus.bus_be, 4'b1100);
      check("sh_wdata", bus.bus_wdata, 32'hABCD_ABCD);
      check("sh_busy", busy_mem, 0);
      tick();
      bus.bus_gnt = 1'b0;
      @(negedge clk);
      check("sh_after_req", bus.bus_req, 0);

      // lw 0x3004 with grant withheld 3 cycles, a store waiting in EXE
      exe_op(1, 0, 2'd2, 0, 32'h3004, 32'h0, 1, 5'd7, 32'h0);
      tick();
      exe_op(0, 1, 2'd2, 0, 32'h4000, 32'h5555_AAAA, 0, 5'd0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("nogt_req", bus.bus_req, 1);
         check("nogt_addr", bus.bus_addr, 32'h3004);
         check("nogt_busy", busy_mem, 1);
         tick();
      end
      bus.bus_gnt = 1'b1;
      @(negedge clk);
      check("gnt_req", bus.bus_req, 1);
      check("gnt_addr", bus.bus_addr, 32'h3004);
      check("gnt_busy", busy_mem, 1);
      tick();
      bus.bus_gnt = 1'b0;
      @(negedge clk);
      check("wait_busy", busy_mem, 1);
      check("wait_req", bus.bus_req, 0);
      check("wait_waddr", reg_waddr_mem, 7);
      tick();
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'hCAFE_F00D;
      @(negedge clk);
      check("lw_busy", busy_mem, 0);
      check("lw_data", reg_wdata_mem, 32'hCAFE_F00D);
      check("lw_waddr", reg_waddr_mem, 7);
      tick();
      bus.bus_rvalid = 1'b0;
      exe_idle();
      bus.bus_gnt = 1'b1;
      @(negedge clk);
      check("sw_we", bus.bus_we, 1);
      check("sw_addr", bus.bus_addr, 32'h4000);
      check("sw_wdata", bus.bus_wdata, 32'h5555_AAAA);
      check("sw_be", bus.bus_be, 4'hF);
      check("sw_busy", busy_mem, 0);
      tick();
      bus.bus_gnt = 1'b0;

      // lhu 0x5002 with clear during WAIT
      exe_op(1, 0, 2'd1, 1, 32'h5002, 32'h0, 1, 5'd9, 32'h0);
      tick();
      exe_idle();
      bus.bus_gnt = 1'b1;
      @(negedge clk);
      check("clr_busy_c0", busy_mem, 1);
      tick();
      bus.bus_gnt = 1'b0;
      clear_ctl   = 1'b1;
      @(negedge clk);
      check("clr_busy_wait", busy_mem, 1);
      tick();
      clear_ctl      = 1'b0;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'h8001_0000;
      exe_op(0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 5'd3, 32'h77);
      @(negedge clk);
      check("clr_busy_done", busy_mem, 0);
      check("clr_wen", reg_wen_mem, 0);
      check("clr_data", reg_wdata_mem, 32'h0000_8001);
      tick();
      bus.bus_rvalid = 1'b0;
      @(negedge clk);
      check("clr_bubble_wen", reg_wen_mem, 0);
      check("clr_bubble_waddr", reg_waddr_mem, 0);
      tick();
      @(negedge clk);
      check("clr_next_wen", reg_wen_mem, 1);
      check("clr_next_waddr", reg_waddr_mem, 3);
      check("clr_next_wdata", reg_wdata_mem, 32'h77);
      exe_idle();
      tick();

      // lw 0x6000, hold across completion and two more cycles, clear alongside hold
      exe_op(1, 0, 2'd2, 0, 32'h6000, 32'h0, 1, 5'd4, 32'h0);
      tick();
      exe_idle();
      bus.bus_gnt = 1'b1;
      tick();
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'hDEAD_BEEF;
      hold_ctl       = 1'b1;
      @(negedge clk);
      check("hold_c0_data", reg_wdata_mem, 32'hDEAD_BEEF);
      check("hold_c0_busy", busy_mem, 0);
      tick();
      bus.bus_rvalid = 1'b0;
      bus.bus_rdata  = 32'h1234_5678;
      exe_op(0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 5'd11, 32'h99);
      @(negedge clk);
      check("hold_c1_data", reg_wdata_mem, 32'hDEAD_BEEF);
      check("hold_c1_waddr", reg_waddr_mem, 4);
      check("hold_c1_wen", reg_wen_mem, 1);
      tick();
      clear_ctl = 1'b1;
      @(negedge clk);
      check("hold_c2_data", reg_wdata_mem, 32'hDEAD_BEEF);
      tick();
      clear_ctl = 1'b0;
      hold_ctl  = 1'b0;
      @(negedge clk);
      check("holdclr_waddr", reg_waddr_mem, 4);
      check("holdclr_data", reg_wdata_mem, 32'hDEAD_BEEF);
      tick();
      @(negedge clk);
      check("hold_rel_waddr", reg_waddr_mem, 11);
      check("hold_rel_data", reg_wdata_mem, 32'h99);
      exe_idle();
      tick();

      // lbu 0x0011: zero extension of a negative byte
      exe_op(1, 0, 2'd0, 1, 32'h0011, 32'h0, 1, 5'd8, 32'h0);
      tick();
      exe_idle();
      bus.bus_gnt = 1'b1;
      @(negedge clk);
      check("lbu_be", bus.bus_be, 4'b0010);
      tick();
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'h0000_9A00;
      @(negedge clk);
      check("lbu_data", reg_wdata_mem, 32'h0000_009A);
      tick();
      bus.bus_rvalid = 1'b0;

      // lw 0x1002: misaligned word
      exe_op(1, 0, 2'd2, 0, 32'h1002, 32'h0, 1, 5'd6, 32'h0);
      tick();
      exe_idle();
`ifdef LSU_MISALIGN_TRAP_EN
      @(negedge clk);
      check("mis_flag", misalign_mem, 1);
      check("mis_req", bus.bus_req, 0);
      check("mis_wen", reg_wen_mem, 0);
      tick();
      @(negedge clk);
      check("mis_flag_done", misalign_mem, 1);
      check("mis_busy_done", busy_mem, 0);
      check("mis_req_done", bus.bus_req, 0);
      tick();
`else
      bus.bus_gnt = 1'b1;
      @(negedge clk);
      check("mis_flag", misalign_mem, 0);
      check("mis_req", bus.bus_req, 1);
      check("mis_addr", bus.bus_addr, 32'h1000);
      check("mis_be", bus.bus_be, 4'hF);
      tick();
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'h0BAD_F00D;
      @(negedge clk);
      check("mis_data", reg_wdata_mem, 32'h0BAD_F00D);
      check("mis_wen", reg_wen_mem, 1);
      check("mis_busy", busy_mem, 0);
      tick();
      bus.bus_rvalid = 1'b0;
`endif

      // reset while a request is pending; a later rvalid is ignored
      exe_op(1, 0, 2'd2, 0, 32'h7000, 32'h0, 1, 5'd2, 32'h0);
      tick();
      exe_idle();
      @(negedge clk);
      check("rma_req_pre", bus.bus_req, 1);
      tick();
      rst_b = 1'b0;
      @(negedge clk);
      check("rma_req", bus.bus_req, 0);
      check("rma_busy", busy_mem, 0);
      check("rma_wen", reg_wen_mem, 0);
      tick();
      rst_b          = 1'b1;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      check("rma_rv_busy", busy_mem, 0);
      check("rma_rv_wen", reg_wen_mem, 0);
      check("rma_rv_wdata", reg_wdata_mem, 0);
      check("rma_rv_req", bus.bus_req, 0);
      tick();
      bus.bus_rvalid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
